// File: rtl/car_collision.sv
// Frog/car collision detector with life counter, respawn hold window and game-over FSM.
// Optional build macro CAR_COLLISION_LANE_EN adds the hit_lane output.
module car_collision #(
    parameter int CAR_W       = 32,
    parameter int FROG_W      = 32,
    parameter int LANE_Y0     = 96,
    parameter int LANE_H      = 32,
    parameter int LIVES_INIT  = 3,
    parameter int HOLD_CYCLES = 25000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [9:0] frog_x,
    input  logic [9:0] frog_y,
    input  logic [9:0] car_x1,
    input  logic [9:0] car_x2,
    input  logic [9:0] car_x3,
    input  logic [9:0] car_x4,
    input  logic [9:0] car_x5,
    input  logic [9:0] car_x6,
    input  logic [9:0] car_x7,
    input  logic [9:0] car_x8,
    input  logic       restart,
    output logic       hit,
    output logic [1:0] lives,
    output logic       respawn,
    output logic       game_over,
`ifdef CAR_COLLISION_LANE_EN
    output logic [2:0] hit_lane,
`endif
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        ALIVE = 2'd0,
        HOLD  = 2'd1,
        OVER  = 2'd2
    } state_t;

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    state_t        state_q, state_d;
    logic [1:0]    lives_q, lives_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          col_q, col_d;

    logic [9:0] cars [8];
    logic       lane_hit;
    logic [2:0] lane_idx;
    logic [9:0] car_sel;
    logic [9:0] d1, d2;
    logic       overlap;

    assign cars = '{car_x1, car_x2, car_x3, car_x4, car_x5, car_x6, car_x7, car_x8};

    // Lane decode by range compare; rows outside the eight lanes never collide.
    always_comb begin
        lane_hit = 1'b0;
        lane_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (({22'd0, frog_y} >= LANE_Y0 + i * LANE_H) &&
                ({22'd0, frog_y} <  LANE_Y0 + (i + 1) * LANE_H)) begin
                lane_hit = 1'b1;
                lane_idx = 3'(i);
            end
        end
    end

    // 10-bit wrapping distances handle cars straddling the 1023->0 seam for free.
    assign car_sel = cars[lane_idx];
    assign d1      = frog_x - car_sel;
    assign d2      = car_sel - frog_x;
    assign overlap = lane_hit && (({22'd0, d1} < CAR_W) || ({22'd0, d2} < FROG_W));

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        cnt_d     = cnt_q;
        col_d     = overlap;
        hit       = 1'b0;
        respawn   = 1'b0;
        game_over = 1'b0;
        case (state_q)
            ALIVE: begin
                if (col_q && (lives_q != 2'd0)) begin
                    hit     = 1'b1;
                    lives_d = lives_q - 2'd1;
                    cnt_d   = '0;
                    state_d = (lives_q > 2'd1) ? HOLD : OVER;
                end
            end
            HOLD: begin
                respawn = 1'b1;
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    col_d   = 1'b0;
                    state_d = ALIVE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            OVER: begin
                game_over = 1'b1;
                lives_d   = 2'd0;
            end
            default: state_d = ALIVE;
        endcase
        // A new-game request beats any collision seen in the same cycle.
        if (restart) begin
            hit     = 1'b0;
            state_d = ALIVE;
            lives_d = 2'(LIVES_INIT);
            cnt_d   = '0;
            col_d   = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ALIVE;
            lives_q <= 2'(LIVES_INIT);
            cnt_q   <= '0;
            col_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
        end
    end

    assign lives     = lives_q;
    assign state_dbg = state_q;

`ifdef CAR_COLLISION_LANE_EN
    logic [2:0] col_lane_q;
    logic [2:0] hit_lane_q;

    // The lane travels with the registered flag so it matches the hit it explains.
    always_ff @(posedge CLK) begin
        col_lane_q <= lane_idx;
        if (RST || restart) begin
            hit_lane_q <= 3'd0;
        end else if (hit) begin
            hit_lane_q <= col_lane_q;
        end
    end

    assign hit_lane = hit ? col_lane_q : hit_lane_q;
`endif

endmodule

// File: tb/tb_car_collision.sv
// Randomized and directed bench for car_collision against a lane/overlap reference model.
module tb_car_collision;

  localparam int HOLD = 8;

  logic       CLK = 1'b0;
  logic       RST;
  logic       restart;
  logic [9:0] frog_x, frog_y;
  logic [9:0] car [8];
  logic       hit, respawn, game_over;
  logic [1:0] lives, state_dbg;
`ifdef CAR_COLLISION_LANE_EN
  logic [2:0] hit_lane;
`endif

  always #5 CLK = ~CLK;

  car_collision #(.HOLD_CYCLES(HOLD)) dut (
    .CLK(CLK), .RST(RST), .frog_x(frog_x), .frog_y(frog_y),
    .car_x1(car[0]), .car_x2(car[1]), .car_x3(car[2]), .car_x4(car[3]),
    .car_x5(car[4]), .car_x6(car[5]), .car_x7(car[6]), .car_x8(car[7]),
    .restart(restart), .hit(hit), .lives(lives), .respawn(respawn),
    .game_over(game_over),
`ifdef CAR_COLLISION_LANE_EN
    .hit_lane(hit_lane),
`endif
    .state_dbg(state_dbg)
  );

  int total = 0;
  int bad = 0;
  logic [1:0] exp_q[$];

  // reference model: mode 0 playing, 1 respawn window, 2 game over
  int m_mode, m_lives, m_left, m_pend, m_pend_lane, m_hl;
  bit obs_hit, obs_resp;
  int hits_cnt, resp_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int lane_of(input logic [9:0] y);
    int yi;
    yi = int'(y);
    if (yi >= 96 && yi < 96 + 8 * 32) return (yi - 96) / 32 + 1;
    return 0;
  endfunction

  function automatic int overlaps();
    int ln, fx, cx, dd1, dd2;
    ln = lane_of(frog_y);
    if (ln == 0) return 0;
    fx = int'(frog_x);
    cx = int'(car[ln - 1]);
    dd1 = (fx - cx + 1024) % 1024;
    dd2 = (cx - fx + 1024) % 1024;
    return (dd1 < 32 || dd2 < 32) ? 1 : 0;
  endfunction

  task automatic model_edge();
    int ov, ln;
    ov = overlaps();
    ln = lane_of(frog_y);
    if (RST) begin
      m_mode = 0; m_lives = 3; m_left = 0; m_pend = 0; m_hl = 0;
      exp_q.delete();
    end else if (restart) begin
      m_mode = 0; m_lives = 3; m_left = 0; m_pend = 0; m_hl = 0;
    end else begin
      case (m_mode)
        0: begin
          if (m_pend != 0) begin
            m_lives = m_lives - 1;
            m_hl = m_pend_lane;
            exp_q.push_back(2'(m_lives));
            m_mode = (m_lives > 0) ? 1 : 2;
            m_left = HOLD;
          end
          m_pend = ov;
        end
        1: begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_mode = 0;
            m_pend = 0;
          end else begin
            m_pend = ov;
          end
        end
        default: m_pend = ov;
      endcase
    end
    m_pend_lane = ln - 1;
  endtask

  // One clock: compare outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    bit exp_hit;
    @(negedge CLK);
    exp_hit = (m_mode == 0) && (m_pend != 0) && !restart;
    check("hit", hit, exp_hit);
    check("respawn", respawn, m_mode == 1);
    check("game_over", game_over, m_mode == 2);
    check("lives", lives, m_lives);
`ifdef CAR_COLLISION_LANE_EN
    check("hit_lane", hit_lane, exp_hit ? 3'(m_pend_lane) : 3'(m_hl));
`endif
    if (exp_q.size() > 0) check("lives_after_hit", lives, exp_q.pop_front());
    obs_hit = hit;
    obs_resp = respawn;
    if (hit) hits_cnt++;
    if (respawn) resp_cnt++;
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_counts();
    hits_cnt = 0;
    resp_cnt = 0;
  endtask

  task automatic set_cars(input logic [9:0] v);
    for (int i = 0; i < 8; i++) car[i] = v;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  task automatic wait_hit(input string tag, input int budget);
    bit found;
    found = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (obs_hit) begin
        found = 1;
        break;
      end
    end
    check(tag, found, 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold_hits, fall_idx, hit_idx, resp_after_over;
    bit seen_resp;
    int ln;

    // clock/reset
    RST = 1'b1; restart = 1'b0; frog_x = 10'd0; frog_y = 10'd0; set_cars(10'd0);
    m_mode = 0; m_lives = 3; m_left = 0; m_pend = 0; m_pend_lane = 0; m_hl = 0;
    repeat (2) @(posedge CLK);
    model_edge();
    #1;
    RST = 1'b0;
    check("rst_lives", lives, 3);
    check("rst_hit", hit, 0);
    check("rst_respawn", respawn, 0);
    check("rst_game_over", game_over, 0);

    // lane 3 hit and hold length
    set_cars(10'd600);
    frog_y = 10'd170; frog_x = 10'd200; car[2] = 10'd190;
    clear_counts();
    step();
    check("lane3_not_yet", obs_hit, 0);
    step();
    check("lane3_hit", obs_hit, 1);
    car[2] = 10'd600;
    clear_counts();
    run(20);
    check("lane3_respawn_cycles", resp_cnt, HOLD);
    check("lane3_extra_hits", hits_cnt, 0);
    check("lane3_lives", lives, 2);

    // wrap-around overlap in lane 1
    do_restart();
    frog_y = 10'd100; frog_x = 10'd5; car[0] = 10'd1010;
    clear_counts();
    run(3);
    check("wrap_hit", hits_cnt, 1);
    car[0] = 10'd980;
    run(12);
    clear_counts();
    run(5);
    check("wrap_no_hit", hits_cnt, 0);

    // outside every lane
    do_restart();
    frog_x = 10'd300; set_cars(10'd300);
    clear_counts();
    frog_y = 10'd50;  run(100);
    frog_y = 10'd400; run(100);
    frog_y = 10'd352; run(10);
    frog_y = 10'd95;  run(10);
    check("offlane_hits", hits_cnt, 0);
    check("offlane_lives", lives, 3);

    // hold immunity with overlap kept
    set_cars(10'd600);
    do_restart();
    frog_y = 10'd170; frog_x = 10'd200; car[2] = 10'd190;
    wait_hit("immune_first_hit", 5);
    hold_hits = 0; fall_idx = -1; hit_idx = -1; seen_resp = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (obs_resp) seen_resp = 1;
      if (obs_resp && obs_hit) hold_hits++;
      if (seen_resp && !obs_resp && fall_idx < 0) fall_idx = i;
      if (obs_hit) begin
        hit_idx = i;
        break;
      end
    end
    check("immune_hold_hits", hold_hits, 0);
    check("immune_hit_in_2nd_low_cycle", hit_idx - fall_idx, 1);
    check("immune_lives", lives, 1);

    // game over after three hits
    do_restart();
    clear_counts();
    resp_after_over = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (hits_cnt == 3 && obs_resp) resp_after_over++;
    end
    check("over_hits", hits_cnt, 3);
    check("over_no_hold", resp_after_over, 0);
    check("over_flag", game_over, 1);
    check("over_lives", lives, 0);
    do_restart();
    check("restart_lives", lives, 3);
    check("restart_game_over", game_over, 0);

    // restart beats a pending collision
    set_cars(10'd600);
    run(2);
    car[2] = 10'd190;
    step();
    restart = 1'b1;
    step();
    check("prio_no_hit", obs_hit, 0);
    restart = 1'b0;
    check("prio_lives", lives, 3);

    // RST in the middle of the hold window
    wait_hit("rst_hold_hit", 5);
    run(3);
    check("rst_hold_in_hold", obs_resp, 1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("rst_hold_respawn", respawn, 0);
    check("rst_hold_lives", lives, 3);
    check("rst_hold_game_over", game_over, 0);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        frog_y = 10'($urandom_range(0, 420));
        frog_x = 10'($urandom_range(0, 1023));
        for (int k = 0; k < 8; k++) car[k] = 10'($urandom_range(0, 1023));
        ln = lane_of(frog_y);
        if (ln > 0 && $urandom_range(0, 1) == 1)
          car[ln - 1] = frog_x + 10'($urandom_range(0, 80)) - 10'd40;
      end
      restart = ($urandom_range(0, 49) == 0);
      RST = ($urandom_range(0, 199) == 0);
      step();
    end
    restart = 1'b0;
    RST = 1'b0;
    run(2);
    check("exp_q_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
